seq_scan_ctrl: RTL and testbench

Run controller for serial pattern detection on the `stream` bit line. Software (or a parent FSM) loads a pattern, mask and limits, then pulses `start`. The block scans gated stream beats, counts matches and stops on a target count, window expiry or abort. It reports `done`/`timeout` and exposes the match count.

---
 rtl/seq_scan_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_seq_scan_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: masked serial pattern scanner with match-count target and beat-window stop.
// Define SEQ_SCAN_CTRL_FIRST_POS_EN to add first_pos (window index of the run's first match).
module seq_scan_ctrl #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned WIN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic [WIN_W-1:0] cfg_window,
  input  logic             cfg_overlap,
  input  logic             start,
  input  logic             abort,
  input  logic             stream,
  input  logic             stream_valid,
  output logic             busy,
  output logic             detected,
  output logic [CNT_W-1:0] match_count,
  output logic             done,
  output logic             timeout
`ifdef SEQ_SCAN_CTRL_FIRST_POS_EN
  ,
  output logic [WIN_W-1:0] first_pos
`endif
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e state_q, state_d;

  // The oldest bit is never needed again: a match is judged on the post-shift value.
  logic [PAT_W-2:0]  sh_q, sh_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [PAT_W-1:0]  mask_q, mask_d;
  logic [CNT_W-1:0]  target_q, target_d;
  logic [WIN_W-1:0]  window_q, window_d;
  logic              overlap_q, overlap_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              det_q, det_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
`ifdef SEQ_SCAN_CTRL_FIRST_POS_EN
  logic [WIN_W-1:0]  fpos_q, fpos_d;
`endif

  logic [PAT_W-1:0]  sh_next;
  logic [FILL_W-1:0] fill_inc;
  logic [WIN_W-1:0]  win_inc;
  logic [CNT_W-1:0]  cnt_inc;
  logic              beat, match, hit_target, hit_window, accept_start;

  assign accept_start = (state_q == StIdle) && start && !abort;
  assign beat         = (state_q == StScan) && stream_valid && !abort;
  assign sh_next      = {sh_q, stream};
  assign fill_inc     = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
  assign win_inc      = win_q + WIN_W'(1);
  assign match        = (fill_inc == FILL_FULL) && (((sh_next ^ pat_q) & mask_q) == '0);
  assign cnt_inc      = !match ? cnt_q : ((&cnt_q) ? cnt_q : cnt_q + CNT_W'(1));
  assign hit_target   = (target_q != '0) && (cnt_inc == target_q);
  assign hit_window   = (window_q != '0) && (win_inc == window_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  if (start) state_d = StScan;
        StScan:  if (stream_valid && (hit_target || hit_window)) state_d = StDone;
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    sh_d      = sh_q;
    fill_d    = fill_q;
    win_d     = win_q;
    pat_d     = pat_q;
    mask_d    = mask_q;
    target_d  = target_q;
    window_d  = window_q;
    overlap_d = overlap_q;
    cnt_d     = cnt_q;
    det_d     = 1'b0;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    busy_d    = (state_d != StIdle);
`ifdef SEQ_SCAN_CTRL_FIRST_POS_EN
    fpos_d    = fpos_q;
`endif
    if (accept_start) begin
      pat_d     = cfg_pattern;
      mask_d    = cfg_mask;
      target_d  = cfg_target;
      window_d  = cfg_window;
      overlap_d = cfg_overlap;
      sh_d      = '0;
      fill_d    = '0;
      win_d     = '0;
      cnt_d     = '0;
`ifdef SEQ_SCAN_CTRL_FIRST_POS_EN
      fpos_d    = '0;
`endif
    end else if (beat) begin
      sh_d      = sh_next[PAT_W-2:0];
      // Without overlap, a match consumes its bits: the next one needs a full fresh pattern.
      fill_d    = (match && !overlap_q) ? '0 : fill_inc;
      win_d     = win_inc;
      cnt_d     = cnt_inc;
      det_d     = match;
      done_d    = hit_target || hit_window;
      timeout_d = !hit_target && hit_window;
`ifdef SEQ_SCAN_CTRL_FIRST_POS_EN
      if (match && (cnt_q == '0)) fpos_d = win_inc;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q      <= '0;
      fill_q    <= '0;
      win_q     <= '0;
      pat_q     <= '0;
      mask_q    <= '0;
      target_q  <= '0;
      window_q  <= '0;
      overlap_q <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      det_q     <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
`ifdef SEQ_SCAN_CTRL_FIRST_POS_EN
      fpos_q    <= '0;
`endif
    end else begin
      sh_q      <= sh_d;
      fill_q    <= fill_d;
      win_q     <= win_d;
      pat_q     <= pat_d;
      mask_q    <= mask_d;
      target_q  <= target_d;
      window_q  <= window_d;
      overlap_q <= overlap_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      det_q     <= det_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
`ifdef SEQ_SCAN_CTRL_FIRST_POS_EN
      fpos_q    <= fpos_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign detected    = det_q;
  assign match_count = cnt_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
`ifdef SEQ_SCAN_CTRL_FIRST_POS_EN
  assign first_pos   = fpos_q;
`endif

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Table-driven bench for seq_scan_ctrl: per-cycle vectors checked through a scoreboard queue.
module tb_seq_scan_ctrl;

  localparam int unsigned PAT_W = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned WIN_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [PAT_W-1:0] cfg_pattern, cfg_mask;
  logic [CNT_W-1:0] cfg_target;
  logic [WIN_W-1:0] cfg_window;
  logic             cfg_overlap, start, abort, stream, stream_valid;
  logic             busy, detected, done, timeout;
  logic [CNT_W-1:0] match_count;
`ifdef SEQ_SCAN_CTRL_FIRST_POS_EN
  logic [WIN_W-1:0] first_pos;
`endif

  always #5 clk = ~clk;

  seq_scan_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_pattern  (cfg_pattern),
    .cfg_mask     (cfg_mask),
    .cfg_target   (cfg_target),
    .cfg_window   (cfg_window),
    .cfg_overlap  (cfg_overlap),
    .start        (start),
    .abort        (abort),
    .stream       (stream),
    .stream_valid (stream_valid),
    .busy         (busy),
    .detected     (detected),
    .match_count  (match_count),
    .done         (done),
    .timeout      (timeout)
`ifdef SEQ_SCAN_CTRL_FIRST_POS_EN
    ,
    .first_pos    (first_pos)
`endif
  );

  typedef struct {
    logic [3:0]  pat;
    logic [3:0]  mask;
    logic [7:0]  tgt;
    logic [15:0] win;
    logic        ov;
  } cfg_t;

  // exp = {busy, detected, done, timeout, match_count} after the row's clock edge
  typedef struct {
    string      name;
    int         cfg;
    logic       rst, st, ab, vl, bt;
    logic [11:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [11:0] exp;
  } sb_t;

  cfg_t cfgs[7];
  vec_t vecs[$];
  sb_t  sb_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(input string name, input int c,
                              input logic rst, input logic st, input logic ab,
                              input logic vl, input logic bt,
                              input logic eb, input logic ed, input logic edn,
                              input logic eto, input logic [7:0] ec);
    vec_t v;
    v.name = name;
    v.cfg  = c;
    v.rst  = rst;
    v.st   = st;
    v.ab   = ab;
    v.vl   = vl;
    v.bt   = bt;
    v.exp  = {eb, ed, edn, eto, ec};
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input int c, input logic rst, input logic st, input logic ab,
                       input logic vl, input logic bt);
    cfg_pattern  = cfgs[c].pat;
    cfg_mask     = cfgs[c].mask;
    cfg_target   = cfgs[c].tgt;
    cfg_window   = cfgs[c].win;
    cfg_overlap  = cfgs[c].ov;
    reset        = rst;
    start        = st;
    abort        = ab;
    stream_valid = vl;
    stream       = bt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   n;
    logic seen;
    logic [6:0] bits;

    cfgs[0] = '{4'b1011, 4'b1111, 8'd0, 16'd7, 1'b1};
    cfgs[1] = '{4'b1011, 4'b1111, 8'd0, 16'd7, 1'b0};
    cfgs[2] = '{4'b0000, 4'b1111, 8'd0, 16'd0, 1'b1};  // mid-run change, must be ignored
    cfgs[3] = '{4'b1011, 4'b1111, 8'd1, 16'd4, 1'b1};
    cfgs[4] = '{4'b0111, 4'b0011, 8'd0, 16'd0, 1'b1};
    cfgs[5] = '{4'b1011, 4'b0000, 8'd0, 16'd0, 1'b1};
    cfgs[6] = '{4'b1111, 4'b1111, 8'd0, 16'd3, 1'b1};

    //  name            cfg rst st ab vl bt   busy det done to cnt
    add("rst0",          0, 1, 0, 0, 1, 1,   0, 0, 0, 0, 0);
    add("rst1",          0, 1, 0, 0, 1, 0,   0, 0, 0, 0, 0);
    add("idle0",         0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0);
    add("idle1",         0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0);
    // overlap=1, window 7
    add("ov_start",      0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0);
    add("ov_b1",         0, 0, 0, 0, 1, 1,   1, 0, 0, 0, 0);
    add("ov_b2",         0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 0);
    add("ov_b3",         0, 0, 0, 0, 1, 1,   1, 0, 0, 0, 0);
    add("ov_b4",         0, 0, 0, 0, 1, 1,   1, 1, 0, 0, 1);
    add("ov_b5",         0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 1);
    add("ov_b6",         0, 0, 0, 0, 1, 1,   1, 0, 0, 0, 1);
    add("ov_b7",         0, 0, 0, 0, 1, 1,   1, 1, 1, 1, 2);
    add("ov_idle",       0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 2);
    // overlap=0, config inputs changed after start
    add("nov_start",     1, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0);
    add("nov_b1",        2, 0, 0, 0, 1, 1,   1, 0, 0, 0, 0);
    add("nov_b2",        2, 0, 0, 0, 1, 0,   1, 0, 0, 0, 0);
    add("nov_b3",        2, 0, 0, 0, 1, 1,   1, 0, 0, 0, 0);
    add("nov_b4",        2, 0, 0, 0, 1, 1,   1, 1, 0, 0, 1);
    add("nov_b5",        2, 0, 0, 0, 1, 0,   1, 0, 0, 0, 1);
    add("nov_b6",        2, 0, 0, 0, 1, 1,   1, 0, 0, 0, 1);
    add("nov_b7",        2, 0, 0, 0, 1, 1,   1, 0, 1, 1, 1);
    add("nov_idle",      2, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1);
    // target hit on the last window beat, start ignored during DONE
    add("tgt_start",     3, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0);
    add("tgt_b1",        3, 0, 0, 0, 1, 1,   1, 0, 0, 0, 0);
    add("tgt_b2",        3, 0, 0, 0, 1, 0,   1, 0, 0, 0, 0);
    add("tgt_b3",        3, 0, 0, 0, 1, 1,   1, 0, 0, 0, 0);
    add("tgt_b4",        3, 0, 0, 0, 1, 1,   1, 1, 1, 0, 1);
    add("tgt_st_in_done",3, 0, 1, 0, 0, 0,   0, 0, 0, 0, 1);
    add("tgt_idle",      3, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1);
    // partial mask with gaps in stream_valid, unlimited run ended by abort
    add("msk_start",     4, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0);
    add("msk_v1",        4, 0, 0, 0, 1, 0,   1, 0, 0, 0, 0);
    add("msk_g1",        4, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0);
    add("msk_v2",        4, 0, 0, 0, 1, 0,   1, 0, 0, 0, 0);
    add("msk_g2",        4, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0);
    add("msk_v3",        4, 0, 0, 0, 1, 1,   1, 0, 0, 0, 0);
    add("msk_g3",        4, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0);
    add("msk_v4",        4, 0, 0, 0, 1, 1,   1, 1, 0, 0, 1);
    add("msk_g4",        4, 0, 0, 0, 0, 0,   1, 0, 0, 0, 1);
    add("msk_abort",     4, 0, 0, 1, 1, 1,   0, 0, 0, 0, 1);
    // all-zero mask, start while busy, abort+start, restart, reset mid-run
    add("zm_start",      5, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0);
    add("zm_b1",         5, 0, 0, 0, 1, 1,   1, 0, 0, 0, 0);
    add("zm_b2",         5, 0, 0, 0, 1, 0,   1, 0, 0, 0, 0);
    add("zm_b3",         5, 0, 0, 0, 1, 1,   1, 0, 0, 0, 0);
    add("zm_b4",         5, 0, 0, 0, 1, 1,   1, 1, 0, 0, 1);
    add("zm_b5_start",   5, 0, 1, 0, 1, 0,   1, 1, 0, 0, 2);
    add("zm_abort_start",5, 0, 1, 1, 1, 1,   0, 0, 0, 0, 2);
    add("zm_idle",       5, 0, 0, 0, 0, 0,   0, 0, 0, 0, 2);
    add("zm_restart",    5, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0);
    add("zm_r1",         5, 0, 0, 0, 1, 0,   1, 0, 0, 0, 0);
    add("zm_r2",         5, 0, 0, 0, 1, 0,   1, 0, 0, 0, 0);
    add("zm_r3",         5, 0, 0, 0, 1, 0,   1, 0, 0, 0, 0);
    add("zm_r4",         5, 0, 0, 0, 1, 0,   1, 1, 0, 0, 1);
    add("zm_reset",      5, 1, 0, 0, 1, 1,   0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      sb_t e;
      sb_q.push_back('{vecs[i].name, vecs[i].exp});
      drive(vecs[i].cfg, vecs[i].rst, vecs[i].st, vecs[i].ab, vecs[i].vl, vecs[i].bt);
      e = sb_q.pop_front();
      check(e.name, {20'd0, busy, detected, done, timeout, match_count}, {20'd0, e.exp});
    end

    // Window expiry with no matches, bounded wait for done.
    drive(6, 0, 1, 0, 0, 0);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      drive(6, 0, 0, 0, 1, 0);
      n++;
      seen = done;
    end
    check("win_done_seen", {31'd0, seen}, 32'd1);
    check("win_beats", n, 3);
    check("win_timeout", {31'd0, timeout}, 32'd1);
    check("win_count", {24'd0, match_count}, 32'd0);
    drive(6, 0, 0, 0, 0, 0);
    check("win_busy_drop", {31'd0, busy}, 32'd0);

`ifdef SEQ_SCAN_CTRL_FIRST_POS_EN
    drive(0, 0, 1, 0, 0, 0);
    check("fpos_cleared", {16'd0, first_pos}, 32'd0);
    bits = 7'b1011011;
    for (int k = 6; k >= 0; k--) drive(0, 0, 0, 0, 1, bits[k]);
    drive(0, 0, 0, 0, 0, 0);
    check("fpos_first", {16'd0, first_pos}, 32'd4);
`else
    bits = '0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
